// File: rtl/exu_md_pkg.sv
// Shared opcode and state encodings for the exu_md execute stage.
package exu_md_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_PASS2  = 5'd10,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_OUT
  } state_e;

  function automatic logic is_m_op(input logic [4:0] op);
    return (op >= 5'd16) && (op <= 5'd23);
  endfunction

  function automatic logic is_alu_op(input logic [4:0] op);
    return op <= 5'd10;
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= 5'd20) && (op <= 5'd23);
  endfunction

  function automatic logic src1_signed(input logic [4:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic src2_signed(input logic [4:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/exu_md_md_iter.sv
// Iterative multiply/divide unit: WIDTH steps of shift-add or restoring
// division on operand magnitudes, with a sign fixup on the final step.
module md_iter
  import exu_md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opd_q, opd_d, dvd_q, dvd_d;
  logic             is_div_q, is_div_d, neg_q, neg_d;
  logic             hi_sel_q, hi_sel_d, rem_sel_q, rem_sel_d, dvz_q, dvz_d;

  logic             sa, sb;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   sum, trial;
  logic [WIDTH-1:0] step_hi, step_lo, dval, dval_s;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign sa   = src1_signed(op_i) & src1_i[WIDTH-1];
  assign sb   = src2_signed(op_i) & src2_i[WIDTH-1];
  assign mag1 = sa ? (~src1_i + 1'b1) : src1_i;
  assign mag2 = sb ? (~src2_i + 1'b1) : src2_i;

  // hi/lo hold {partial product, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  always_comb begin
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opd_q};
    if (is_div_q) begin
      step_hi = trial[WIDTH] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : trial[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~trial[WIDTH]};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = {step_hi, step_lo};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    dval   = rem_sel_q ? step_hi : step_lo;
    dval_s = neg_q ? (~dval + 1'b1) : dval;
    if (is_div_q) begin
      if (dvz_q) result_o = rem_sel_q ? dvd_q : '1;
      else       result_o = dval_s;
    end else begin
      result_o = hi_sel_q ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
    end
  end

  assign done_o = (cnt_q == CW'(1));

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opd_d     = opd_q;
    dvd_d     = dvd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    hi_sel_d  = hi_sel_q;
    rem_sel_d = rem_sel_q;
    dvz_d     = dvz_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      cnt_d     = CW'(WIDTH);
      hi_d      = '0;
      lo_d      = mag1;
      opd_d     = mag2;
      dvd_d     = src1_i;
      is_div_d  = is_div_op(op_i);
      rem_sel_d = op_i inside {OP_REM, OP_REMU};
      hi_sel_d  = op_i inside {OP_MULH, OP_MULHSU, OP_MULHU};
      neg_d     = rem_sel_d ? sa : (sa ^ sb);
      dvz_d     = (src2_i == '0);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      hi_d  = step_hi;
      lo_d  = step_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opd_q     <= '0;
      dvd_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      hi_sel_q  <= 1'b0;
      rem_sel_q <= 1'b0;
      dvz_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opd_q     <= opd_d;
      dvd_q     <= dvd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      hi_sel_q  <= hi_sel_d;
      rem_sel_q <= rem_sel_d;
      dvz_q     <= dvz_d;
    end
  end

endmodule

// File: rtl/exu_md.sv
// Execute stage: single-cycle ALU plus optional iterative M unit, with a
// registered valid/ready output carrying the op's sideband tag.
module exu_md
  import exu_md_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 64,
  parameter bit          HAS_M = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             accept, m_go, md_start, md_done;
  logic [WIDTH-1:0] md_result, alu_res;
  logic [SHW-1:0]   shamt;

  assign in_ready = ~flush & ((state_q == S_IDLE) | ((state_q == S_OUT) & out_ready));
  assign accept   = in_valid & in_ready;
  assign m_go     = HAS_M & is_m_op(in_op);
  assign md_start = accept & m_go;
  assign shamt    = in_src2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD:   alu_res = in_src1 + in_src2;
      OP_SUB:   alu_res = in_src1 - in_src2;
      OP_SLL:   alu_res = in_src1 << shamt;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(in_src1) < $signed(in_src2)};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, in_src1 < in_src2};
      OP_XOR:   alu_res = in_src1 ^ in_src2;
      OP_SRL:   alu_res = in_src1 >> shamt;
      OP_SRA:   alu_res = $signed(in_src1) >>> shamt;
      OP_OR:    alu_res = in_src1 | in_src2;
      OP_AND:   alu_res = in_src1 & in_src2;
      OP_PASS2: alu_res = in_src2;
      default:  alu_res = '0;
    endcase
  end

  generate
    if (HAS_M) begin : g_md
      md_iter #(.WIDTH(WIDTH)) u_md_iter (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush),
        .start_i  (md_start),
        .op_i     (in_op),
        .src1_i   (in_src1),
        .src2_i   (in_src2),
        .done_o   (md_done),
        .result_o (md_result)
      );
    end else begin : g_no_md
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    illegal_d   = illegal_q;
    tag_d       = tag_q;
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_OUT: begin
          if ((state_q == S_OUT) && out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end
          if (accept) begin
            tag_d = in_tag;
            if (m_go) begin
              state_d     = S_BUSY;
              out_valid_d = 1'b0;
            end else begin
              state_d     = S_OUT;
              out_valid_d = 1'b1;
              illegal_d   = ~is_alu_op(in_op);
              result_d    = is_alu_op(in_op) ? alu_res : '0;
            end
          end
        end
        S_BUSY: begin
          if (md_done) begin
            state_d     = S_OUT;
            out_valid_d = 1'b1;
            result_d    = md_result;
            illegal_d   = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
      tag_q       <= tag_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = result_q;
  assign out_zero    = (result_q == '0);
  assign out_illegal = illegal_q;
  assign out_tag     = tag_q;

endmodule

// File: tb/tb_exu_md.sv
// Scoreboard bench for exu_md: directed corners plus randomized ops against
// an arithmetic reference model.
module tb_exu_md;

  typedef struct packed {
    logic [31:0] res;
    logic        ill;
    logic [63:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [4:0]  in_op = '0;
  logic [31:0] in_src1 = '0, in_src2 = '0;
  logic [63:0] in_tag = '0;
  logic        out_valid, out_ready = 1'b1, out_zero, out_illegal;
  logic [31:0] out_result;
  logic [63:0] out_tag;

  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_zero2, out_illegal2;
  logic [4:0]  in_op2 = '0;
  logic [31:0] out_result2;
  logic [63:0] in_tag2 = '0, out_tag2;

  int   n_checks = 0, n_pass = 0;
  bit   rnd_mode = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  exu_md #(.WIDTH(32), .TAG_W(64), .HAS_M(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .out_tag(out_tag));

  exu_md #(.WIDTH(32), .TAG_W(64), .HAS_M(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_op(in_op2), .in_src1(32'd6), .in_src2(32'd7), .in_tag(in_tag2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_result(out_result2),
    .out_zero(out_zero2), .out_illegal(out_illegal2), .out_tag(out_tag2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] tag);
    exp_t   e;
    longint sa, sbv, ua, ub, p;
    int     ia, ib;
    sa = longint'($signed(a)); sbv = longint'($signed(b));
    ua = {32'b0, a}; ub = {32'b0, b};
    ia = a; ib = b;
    e.tag = tag; e.ill = 1'b0; e.res = '0; p = 0;
    case (op)
      5'd0:  e.res = a + b;
      5'd1:  e.res = a - b;
      5'd2:  e.res = a << b[4:0];
      5'd3:  e.res = (ia < ib) ? 32'd1 : 32'd0;
      5'd4:  e.res = (a < b) ? 32'd1 : 32'd0;
      5'd5:  e.res = a ^ b;
      5'd6:  e.res = a >> b[4:0];
      5'd7:  e.res = 32'(ia >>> b[4:0]);
      5'd8:  e.res = a | b;
      5'd9:  e.res = a & b;
      5'd10: e.res = b;
      5'd16: begin p = sa * sbv; e.res = p[31:0];  end
      5'd17: begin p = sa * sbv; e.res = p[63:32]; end
      5'd18: begin p = sa * ub;  e.res = p[63:32]; end
      5'd19: begin p = ua * ub;  e.res = p[63:32]; end
      5'd20: e.res = (b == 0) ? 32'hFFFFFFFF :
                     (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(ia / ib);
      5'd21: e.res = (b == 0) ? 32'hFFFFFFFF : a / b;
      5'd22: e.res = (b == 0) ? a :
                     (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(ia % ib);
      5'd23: e.res = (b == 0) ? a : a % b;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Monitor: every handshaked output is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got %0h expected none", out_result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", 64'(out_result), 64'(e.res));
        chk("illegal", 64'(out_illegal), 64'(e.ill));
        chk("tag", out_tag, e.tag);
        chk("zero", 64'(out_zero), 64'(e.res == 0));
      end
    end
  end

  // Drives one op until accepted; waits = number of negedges sampled.
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] tag, output int waits);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
    waits = 0;
    forever begin
      @(negedge clk);
      waits++;
      if (in_ready) break;
      if (waits >= 200) begin
        n_checks++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rnd_mode) out_ready = ($urandom_range(0, 2) != 0);
    end
    sb_q.push_back(model(op, a, b, tag));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 300) begin @(posedge clk); n++; end
    #1;
  endtask

  initial begin
    int w, lat;
    logic [31:0] vals [6];
    logic [4:0]  ops [21];
    vals = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h5};
    ops  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
             5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd12, 5'd31};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_zero", 64'(out_zero), 64'd1);
    chk("rst_tag", out_tag, 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // ALU back-to-back
    send(5'd0, 32'd5, 32'd7, 64'hA1, w);          chk("b2b_wait0", 64'(w), 64'd1);
    send(5'd1, 32'd3, 32'd5, 64'hA2, w);          chk("b2b_wait1", 64'(w), 64'd1);
    send(5'd7, 32'h80000000, 32'd4, 64'hA3, w);   chk("b2b_wait2", 64'(w), 64'd1);
    drain();

    // Backpressure
    out_ready = 1'b0;
    send(5'd5, 32'hFF, 32'h0F, 64'hB1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", 64'(out_result), 64'hF0);
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(5'd8, 32'h10, 32'h01, 64'hB2, w);       chk("bp_accept", 64'(w), 64'd1);
    drain();

    // MULH / MULHU latency
    send(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hC1, w);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) chk("busy_ready", 64'(in_ready), 64'd0);
    end
    chk("mulh_latency", 64'(lat), 64'd33);
    @(posedge clk); #1;
    send(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hC2, w);
    drain();

    // Divide corners
    send(5'd20, 32'd7, 32'd0, 64'hD1, w);
    send(5'd22, 32'd7, 32'd0, 64'hD2, w);
    send(5'd20, 32'h80000000, 32'hFFFFFFFF, 64'hD3, w);
    send(5'd22, 32'h80000000, 32'hFFFFFFFF, 64'hD4, w);
    send(5'd20, -32'sd7, 32'd2, 64'hD5, w);
    send(5'd22, -32'sd7, 32'd2, 64'hD6, w);
    send(5'd21, 32'd100, 32'd0, 64'hD7, w);
    wait_valid(lat);
    chk("divz_latency", 64'(lat), 64'd33);
    drain();

    // Flush mid-divide
    send(5'd21, 32'd1000, 32'd7, 64'hE1, w);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    void'(sb_q.pop_back());
    @(negedge clk);
    chk("flush_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("post_flush_ready", 64'(in_ready), 64'd1);
    chk("post_flush_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send(5'd0, 32'd1, 32'd1, 64'hE2, w);
    wait_valid(lat);
    chk("flush_add_latency", 64'(lat), 64'd1);
    drain();

    // HAS_M=0: MUL and op 31 are illegal at latency 1
    in_valid2 = 1'b1; in_op2 = 5'd16; in_tag2 = 64'hF1;
    @(posedge clk); #1;
    in_op2 = 5'd31; in_tag2 = 64'hF2;
    @(negedge clk);
    chk("nom_mul_valid", 64'(out_valid2), 64'd1);
    chk("nom_mul_ill", 64'(out_illegal2), 64'd1);
    chk("nom_mul_res", 64'(out_result2), 64'd0);
    chk("nom_mul_tag", out_tag2, 64'hF1);
    @(posedge clk); #1 in_valid2 = 1'b0;
    @(negedge clk);
    chk("nom_op31_valid", 64'(out_valid2), 64'd1);
    chk("nom_op31_ill", 64'(out_illegal2), 64'd1);
    chk("nom_op31_tag", out_tag2, 64'hF2);
    @(posedge clk); #1;
    send(5'd31, 32'd3, 32'd4, 64'hF3, w);
    drain();

    // Reset mid-MUL
    send(5'd16, 32'd123, 32'd456, 64'hF4, w);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_result", 64'(out_result), 64'd0);
    chk("mrst_zero", 64'(out_zero), 64'd1);
    chk("mrst_ill", 64'(out_illegal), 64'd0);
    chk("mrst_tag", out_tag, 64'd0);
    chk("mrst_ready", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    chk("mrst_no_output", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    rnd_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 2) == 0) ? vals[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? vals[$urandom_range(0, 5)] : $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      send(ops[$urandom_range(0, 20)], a, b, {$urandom, $urandom}, w);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rnd_mode = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exu_md.md
Name: exu_md

Overview:
- Parametrised execute stage with a registered valid/ready output.
- ALU ops complete in 1 cycle, at 1 op/cycle throughput.
- Optional RV-M multiply/divide ops run on an iterative shift-add/restoring unit of fixed latency.
- Sits between decode and LSU; carries an opaque sideband tag alongside each result.

Parameters:
WIDTH, 32, datapath width (even, ≥8).
TAG_W, 64, sideband tag width, passed through unmodified.
HAS_M, 1, 1 = M ops implemented; 0 = M ops flagged illegal.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
flush  in  1  discard in-flight and held op
in_valid  in  1  upstream op valid
in_ready  out  1  stage accepts op this cycle
in_op  in  5  opcode (exu_md_pkg::op_e)
in_src1  in  WIDTH  operand 1
in_src2  in  WIDTH  operand 2
in_tag  in  TAG_W  sideband
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_result  out  WIDTH  result
out_zero  out  1  out_result == 0
out_illegal  out  1  op unsupported/unknown
out_tag  out  TAG_W  tag of the accepted op

Behaviour:
- Reset values: state=S_IDLE; out_valid=0; out_result=0; out_tag=0; out_illegal=0; out_zero=1; counter=0.
- Clock and reset: single clk; rst is synchronous, active-high, and overrides everything including an op mid-iteration.
- Accept condition: accept = in_valid & in_ready.
- in_ready = (S_IDLE) | (S_OUT & out_ready); deasserted throughout S_BUSY and while flush=1.
- State S_IDLE:
  - Accept of an ALU op or an illegal op → S_OUT next cycle, result registered.
  - Accept of an M op (HAS_M=1) → S_BUSY, counter=WIDTH.
- State S_BUSY:
  - Counter decrements once per cycle.
  - The cycle counter==1: result written, → S_OUT.
  - Latency accept→out_valid: ALU = 1 cycle; M = WIDTH+1 cycles, fixed for every operand value.
- State S_OUT:
  - out_valid=1; outputs are stable while out_ready=0.
  - If out_ready & in_valid, the next op is accepted the same cycle (back-to-back; S_OUT stays for ALU, → S_BUSY for M).
  - If out_ready & ~in_valid → S_IDLE.
- Flush: flush=1 → S_IDLE, out_valid=0 next cycle, counter cleared; no accept that cycle. Flush wins over out_ready.
- ALU ops:
  - ADD, SUB, XOR, OR, AND, PASS2 (result = src2).
  - SLL, SRL, SRA use shamt = src2[$clog2(WIDTH)-1:0].
  - SLT, SLTU return 1/0 zero-extended.
  - Arithmetic wraps modulo 2^WIDTH.
- Multiply ops:
  - MUL = low WIDTH bits of the product.
  - MULH = high half, signed×signed; MULHSU = high half, signed×unsigned; MULHU = high half, unsigned×unsigned.
  - Implementation: magnitudes through a 2·WIDTH shift-add, then a final conditional negate.
- Divide ops (DIV, DIVU, REM, REMU), restoring on magnitudes, RISC-V semantics:
  - Divisor 0 → quotient all-ones; remainder = dividend.
  - Signed MIN / -1 → quotient MIN; remainder 0.
  - Remainder sign follows the dividend.
  - These cases keep the full fixed latency.
- Illegal ops: opcodes outside op_e, or M ops with HAS_M=0, give result 0 and out_illegal=1 at latency 1.
- Operand and tag capture: operands/tag are captured at accept; later in_* changes are ignored.

Decomposition:
- exu_md_pkg holds:
  - op_e: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS2=10, MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23.
  - state_e: S_IDLE, S_BUSY, S_OUT.
  - is_m_op() helper function.
- Sub-module md_iter: owns the iterative multiply/divide datapath, counter, and sign fixup, with start/done handshake.
- ALU is combinational inline in exu_md.

Test Plan:
1. ALU back-to-back, out_ready=1, WIDTH=32:
   - Stimulus: ADD 5+7, then SUB 3-5, then SRA 0x80000000>>>4.
   - Response: out_valid on 3 consecutive cycles with 12, 0xFFFFFFFE, 0xF8000000; tags preserved; in_ready stays 1.
2. Backpressure:
   - Stimulus: XOR 0xFF^0x0F accepted, out_ready=0 for 5 cycles.
   - Response: out_result=0xF0 held; in_ready=0; the next op is accepted in the cycle out_ready rises.
3. MULH and MULHU:
   - MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000 after exactly 33 cycles.
   - MULHU of the same operands → 0xFFFFFFFE.
   - in_ready=0 while busy.
4. Divide corners:
   - DIV 7/0 → 0xFFFFFFFF; REM 7/0 → 7.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
   - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
5. Flush during S_BUSY:
   - Stimulus: DIVU accepted, flush at cycle 10.
   - Response: out_valid never rises for it; in_ready=1 the next cycle; a following ADD 1+1 returns 2 at latency 1.
6. Illegal ops and mid-op reset:
   - HAS_M=0 with MUL → out_illegal=1, result 0 at latency 1; op 31 → same.
   - rst mid-MUL → all outputs at reset values the next cycle.
